// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter states and a width helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_ODD,
    PARITY_EVEN
  } parity_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  // Counter width that still holds value-1, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned value);
    return ($clog2(value) < 1) ? 1 : $clog2(value);
  endfunction

  // EVEN parity is the plain XOR of the data bits; ODD is its inverse.
  function automatic logic parity_of(input parity_t mode, input logic data_xor);
    return (mode == PARITY_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Valid/ready word stream from a byte producer into the UART transmitter.
interface uart_tx_if #(
  parameter int unsigned NUMBER_OF_BITS = 8
) ();

  logic                      data_valid;
  logic                      data_ready;
  logic [NUMBER_OF_BITS-1:0] data_bits;

  modport master (
    output data_valid,
    output data_bits,
    input  data_ready
  );

  modport slave (
    input  data_valid,
    input  data_bits,
    output data_ready
  );

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period down-counter: load a start value, count down to zero and hold there.
module uart_baud_counter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q, count_d;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-word holding register feeding a start/data/parity/stop serialiser,
// reloading straight from the holding register so back-to-back frames have no idle gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned NUMBER_OF_BITS = 8,
  parameter int unsigned BAUD_DIVIDER   = 4,
  parameter int unsigned STOP_BITS      = 1,
  parameter parity_t     PARITY         = PARITY_NONE
) (
  input  logic       clock,
  input  logic       reset,
  uart_tx_if.slave   data_if,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned RATE_W    = clog2_min1(BAUD_DIVIDER);
  localparam int unsigned BIT_CNT_W = clog2_min1(NUMBER_OF_BITS);

  localparam logic [RATE_W-1:0]    RATE_LOAD = RATE_W'(BAUD_DIVIDER - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(NUMBER_OF_BITS - 1);
  localparam logic                 STOP_LAST = 1'(STOP_BITS - 1);

  if (BAUD_DIVIDER < 1) begin : g_bad_divider
    $error("uart_tx: BAUD_DIVIDER must be at least 1");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (NUMBER_OF_BITS < 1 || NUMBER_OF_BITS > 16) begin : g_bad_width
    $error("uart_tx: NUMBER_OF_BITS must be in 1..16");
  end

  tx_state_t state_q, state_d;
  logic      hold_full_q, hold_full_d;
  logic      ready_q;
  logic      busy_q;
  logic      tx_q, tx_d;

  logic [NUMBER_OF_BITS-1:0] hold_q, hold_d;
  logic [NUMBER_OF_BITS-1:0] shift_q, shift_d;
  logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                      stop_cnt_q, stop_cnt_d;
  logic                      parity_q, parity_d;

  logic baud_load;
  logic baud_zero;
  logic load_frame;
  logic transfer;

  uart_baud_counter #(
    .WIDTH(RATE_W)
  ) u_baud_counter (
    .clock       (clock),
    .reset       (reset),
    .load_i      (baud_load),
    .load_value_i(RATE_LOAD),
    .zero_o      (baud_zero)
  );

  assign transfer = data_if.data_valid && ready_q;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    parity_d    = parity_q;
    tx_d        = tx_q;
    baud_load   = 1'b0;
    load_frame  = 1'b0;

    if (transfer) begin
      hold_d      = data_if.data_bits;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      TX_IDLE: begin
        load_frame = hold_full_q;
      end
      TX_START: begin
        if (baud_zero) begin
          state_d   = TX_DATA;
          baud_load = 1'b1;
          bit_cnt_d = BIT_LAST;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
        end
      end
      TX_DATA: begin
        if (baud_zero) begin
          baud_load = 1'b1;
          if (bit_cnt_q != '0) begin
            bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end else if (PARITY != PARITY_NONE) begin
            state_d = TX_PARITY;
            tx_d    = parity_q;
          end else begin
            state_d    = TX_STOP;
            tx_d       = 1'b1;
            stop_cnt_d = STOP_LAST;
          end
        end
      end
      TX_PARITY: begin
        if (baud_zero) begin
          state_d    = TX_STOP;
          baud_load  = 1'b1;
          tx_d       = 1'b1;
          stop_cnt_d = STOP_LAST;
        end
      end
      TX_STOP: begin
        if (baud_zero) begin
          if (stop_cnt_q != 1'b0) begin
            stop_cnt_d = 1'b0;
            baud_load  = 1'b1;
          end else if (hold_full_q) begin
            load_frame = 1'b1;
          end else begin
            state_d = TX_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Reload from the holding register; ready_q was 0 so no transfer competes for hold this edge.
    if (load_frame) begin
      state_d     = TX_START;
      shift_d     = hold_q;
      parity_d    = parity_of(PARITY, ^hold_q);
      hold_full_d = 1'b0;
      tx_d        = 1'b0;
      baud_load   = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= TX_IDLE;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      ready_q     <= !hold_full_d;
      busy_q      <= (state_d != TX_IDLE) || hold_full_d;
      tx_q        <= tx_d;
    end
  end

  // NOTE: datapath registers are left out of reset; their contents only matter once a valid flag qualifies them.
  always_ff @(posedge clock) begin
    hold_q     <= hold_d;
    shift_q    <= shift_d;
    bit_cnt_q  <= bit_cnt_d;
    stop_cnt_q <= stop_cnt_d;
    parity_q   <= parity_d;
  end

  assign data_if.data_ready = ready_q;
  assign tx                 = tx_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four configurations share one clock and reset.
module tb_uart_tx;
  import uart_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] valid;
  logic [7:0] data_in [4];
  logic [3:0] tx_w, busy_w, ready_w;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc [3];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  uart_tx_if #(.NUMBER_OF_BITS(8)) if0 ();
  uart_tx_if #(.NUMBER_OF_BITS(8)) if1 ();
  uart_tx_if #(.NUMBER_OF_BITS(8)) if2 ();
  uart_tx_if #(.NUMBER_OF_BITS(8)) if3 ();

  assign if0.data_valid = valid[0];
  assign if1.data_valid = valid[1];
  assign if2.data_valid = valid[2];
  assign if3.data_valid = valid[3];
  assign if0.data_bits  = data_in[0];
  assign if1.data_bits  = data_in[1];
  assign if2.data_bits  = data_in[2];
  assign if3.data_bits  = data_in[3];
  assign ready_w = {if3.data_ready, if2.data_ready, if1.data_ready, if0.data_ready};

  uart_tx #(.NUMBER_OF_BITS(8), .BAUD_DIVIDER(4), .STOP_BITS(1), .PARITY(PARITY_NONE)) u_dut0 (
    .clock(clock), .reset(reset), .data_if(if0), .tx(tx_w[0]), .busy(busy_w[0]));
  uart_tx #(.NUMBER_OF_BITS(8), .BAUD_DIVIDER(4), .STOP_BITS(1), .PARITY(PARITY_EVEN)) u_dut1 (
    .clock(clock), .reset(reset), .data_if(if1), .tx(tx_w[1]), .busy(busy_w[1]));
  uart_tx #(.NUMBER_OF_BITS(8), .BAUD_DIVIDER(4), .STOP_BITS(1), .PARITY(PARITY_ODD)) u_dut2 (
    .clock(clock), .reset(reset), .data_if(if2), .tx(tx_w[2]), .busy(busy_w[2]));
  uart_tx #(.NUMBER_OF_BITS(8), .BAUD_DIVIDER(1), .STOP_BITS(2), .PARITY(PARITY_NONE)) u_dut3 (
    .clock(clock), .reset(reset), .data_if(if3), .tx(tx_w[3]), .busy(busy_w[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Offer n words back to back with valid held; records the edge on which each is taken.
  task automatic drive_words(input int idx, input logic [7:0] w0, input logic [7:0] w1,
                             input logic [7:0] w2, input int n);
    logic [7:0] w [3];
    w[0] = w0; w[1] = w1; w[2] = w2;
    for (int i = 0; i < n; i++) begin
      data_in[idx] = w[i];
      valid[idx]   = 1'b1;
      for (int t = 0; t < 200 && ready_w[idx] !== 1'b1; t++) @(negedge clock);
      check($sformatf("accept_w%0d", i), ready_w[idx], 1'b1);
      acc_cyc[i] = cyc + 1;
      @(negedge clock);
    end
    valid[idx] = 1'b0;
  endtask

  // Expected line: bits[i] is the i-th bit period on tx, each lasting div cycles, from the edge after the first transfer.
  task automatic check_stream(input string name, input int idx, input int div,
                              input logic [63:0] bits, input int nbits);
    int len;
    len = nbits * div;
    @(negedge clock);
    check({name, "_tx_pre"},    tx_w[idx],    1'b1);
    check({name, "_busy_pre"},  busy_w[idx],  1'b1);
    check({name, "_ready_pre"}, ready_w[idx], 1'b0);
    for (int c = 0; c < len; c++) begin
      @(negedge clock);
      check($sformatf("%s_tx_c%0d", name, c), tx_w[idx], bits[c / div]);
      if (c == 0) check({name, "_ready_reload"}, ready_w[idx], 1'b1);
      if (c == len - 1) check({name, "_busy_last"}, busy_w[idx], 1'b1);
    end
    @(negedge clock);
    check({name, "_busy_end"}, busy_w[idx], 1'b0);
    check({name, "_tx_end"},   tx_w[idx],   1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lows;
    reset = 1'b0;
    valid = '0;
    for (int i = 0; i < 4; i++) data_in[i] = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_tx",    tx_w[0],    1'b1);
    check("rst_ready", ready_w[0], 1'b0);
    check("rst_busy",  busy_w[0],  1'b0);
    check("rst_tx3",   tx_w[3],    1'b1);
    reset = 1'b1;
    @(negedge clock);
    check("ready_after_rst", ready_w[0], 1'b1);
    check("busy_after_rst",  busy_w[0],  1'b0);

    // 0x55, 8N1, DIV=4: start 0, data 1,0,1,0,1,0,1,0, stop 1.
    fork
      drive_words(0, 8'h55, 8'h00, 8'h00, 1);
      check_stream("f55", 0, 4, 64'({1'b1, 8'h55, 1'b0}), 10);
    join

    // 0x07 has three ones: even parity bit 1, odd parity bit 0.
    fork
      drive_words(1, 8'h07, 8'h00, 8'h00, 1);
      check_stream("even07", 1, 4, 64'({1'b1, 1'b1, 8'h07, 1'b0}), 11);
    join
    fork
      drive_words(2, 8'h07, 8'h00, 8'h00, 1);
      check_stream("odd07", 2, 4, 64'({1'b1, 1'b0, 8'h07, 1'b0}), 11);
    join

    // DIV=1, two stop bits, 0xFF: one low then ten highs.
    fork
      drive_words(3, 8'hFF, 8'h00, 8'h00, 1);
      check_stream("div1ff", 3, 1, 64'({2'b11, 8'hFF, 1'b0}), 11);
    join

    // Back to back: frame 2 start follows frame 1 stop with no gap.
    fork
      drive_words(0, 8'hA5, 8'h3C, 8'h00, 2);
      check_stream("b2b", 0, 4, 64'({1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0}), 20);
    join
    check("b2b_acc2", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);

    // Third word stalls until word 2 loads at edge +41, then is taken at +42.
    fork
      drive_words(0, 8'h11, 8'h22, 8'h33, 3);
      check_stream("three", 0, 4,
                   64'({1'b1, 8'h33, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0}), 30);
    join
    check("three_acc2", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
    check("three_acc3", 32'(acc_cyc[2] - acc_cyc[0]), 32'd42);

    // Reset in the middle of DATA with the holding register full.
    drive_words(0, 8'hC3, 8'h99, 8'h00, 2);
    repeat (12) @(negedge clock);
    check("mid_busy_pre",  busy_w[0],  1'b1);
    check("mid_ready_pre", ready_w[0], 1'b0);
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_tx",    tx_w[0],    1'b1);
    check("mid_rst_ready", ready_w[0], 1'b0);
    check("mid_rst_busy",  busy_w[0],  1'b0);
    reset = 1'b1;
    lows = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) lows++;
    end
    check("post_rst_idle_cycles", 32'(lows), 32'd0);
    check("post_rst_ready", ready_w[0], 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter, the transmit-side counterpart of the team's UART receiver: accepts parallel words over a valid/ready stream and serialises them onto `tx` as 8N1-style frames with optional parity and 1 or 2 stop bits. It sits between a byte-stream producer (command FIFO, debug console) and the FPGA TX pin. A one-entry holding register lets the producer hand over the next word while the current frame is shifting, so back-to-back frames leave no idle gap on the line.

## Interface
- `NUMBER_OF_BITS`, 8, data bits per frame (1..16)
- `BAUD_DIVIDER`, 4, clock cycles per bit (≥1)
- `STOP_BITS`, 1, stop bits per frame (1 or 2)
- `PARITY`, `uart_pkg::PARITY_NONE`, one of NONE / ODD / EVEN
- `clock`  in  1  single clock domain
- `reset`  in  1  synchronous, active-low (0 = reset, sampled on `posedge clock`)
- `data_valid`  in  1  producer has a word
- `data_ready`  out  1  holding register empty
- `data_bits`  in  NUMBER_OF_BITS  word, LSB transmitted first
- `tx`  out  1  serial line, idle high, registered
- `busy`  out  1  frame in progress or holding register full

## Operation
- Transfer occurs on any edge with `data_valid && data_ready`; the word is latched into the holding register and `data_ready` drops on that edge.
- State machine: IDLE, START, DATA, PARITY, STOP.
- IDLE with holding full: next edge loads the shifter from the holding register, clears holding, drives `tx`=0, enters START. The rate counter loads BAUD_DIVIDER-1.
- Each state lasts BAUD_DIVIDER cycles; the rate counter decrements and the state/bit advances when it is 0.
- START → DATA. DATA shifts NUMBER_OF_BITS bits out LSB first via a bit counter, then goes to PARITY if enabled, else STOP.
- Parity bit: EVEN = XOR of the data bits; ODD = inverted XOR. Computed from the shifter contents at load.
- STOP drives `tx`=1 for STOP_BITS×BAUD_DIVIDER cycles. At the end of STOP: if holding is full, go directly to START (reload, `tx`=0 on the same edge); else go to IDLE.
- `busy` = (state ≠ IDLE) || holding full. Registered, consistent with the state.
- `data_ready` is registered and equals !holding-full, except that it is held 0 while in reset.
- `data_bits` is sampled only on the transfer edge; it is don't-care otherwise.
- Rate counter width is max(1, $clog2(BAUD_DIVIDER)); the bit counter is sized for NUMBER_OF_BITS-1. No wrap: counters are only reloaded, never underflow.

## Timing
- Reset (`reset`=0 at an edge): `tx`=1, `data_ready`=0, `busy`=0, state IDLE, holding cleared. Takes effect mid-frame too: the frame is truncated, the line returns high on that edge, and the held word is discarded.
- First edge with `reset`=1: `data_ready` becomes 1.
- Latency: transfer at edge k while IDLE → `tx` falls at edge k+1 → `data_ready` is 1 again after edge k+1.
- Frame length: BAUD_DIVIDER×(1 + NUMBER_OF_BITS + (PARITY≠NONE) + STOP_BITS) cycles, measured from `tx` fall to the next START or IDLE.
- Simultaneous load and transfer: when the shifter empties the holding register and a new word is offered on the same edge, the new word is **not** accepted, because `data_ready` was 0. It is accepted on the following edge. No word is lost or duplicated.
- BAUD_DIVIDER=1: every state advances each cycle; same rules apply.

## Structure
- `uart_pkg`: `parity_t` enum (PARITY_NONE, PARITY_ODD, PARITY_EVEN), shared with the receiver once it gains parity support; `tx_state_t` enum.
- Single module. Optional sub-module `uart_baud_counter` (load/decrement/zero flag), reusable by the receiver.
- Parameter assertions: BAUD_DIVIDER≥1, STOP_BITS∈{1,2}, NUMBER_OF_BITS in 1..16.

## Test plan
- DIV=4, 8N1, send 0x55 after reset: `tx` = 0 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then 1 for 4 cycles; 40 cycles total; then `busy`=0.
- PARITY=EVEN, word 0x07: parity bit 1. PARITY=ODD, word 0x07: parity bit 0. Frame is 44 cycles at DIV=4.
- Back-to-back 0xA5, 0x3C with `data_valid` held: second word accepted during the first frame; the last stop-bit cycle of frame 1 is immediately followed by the start bit of frame 2 (no idle cycle).
- Three words offered continuously: the third is stalled (`data_ready`=0) until the second moves into the shifter, then accepted one edge later. All three appear on `tx` in order.
- `reset`=0 in the middle of DATA with holding full: `tx`=1 on that edge and `data_ready`/`busy`=0. After release, the line stays idle and no stale word is transmitted.
- DIV=1, STOP_BITS=2, 0xFF: frame is 11 cycles (start low, ten highs), and `busy` drops exactly after the 11th cycle.
